// File: rtl/tl_phase_sched.sv
// Four-phase traffic-light scheduler: round-robin green grants with min/max green,
// fixed yellow, and emergency all-red preemption. All outputs are registered.
module tl_phase_sched #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 8,
    parameter int YELLOW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
    input  logic       emg,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [3:0] gnt,
    output logic       chg,
    output logic [3:0] cnt
);

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED} state_t;
    typedef enum logic [1:0] {P_A, P_AL, P_B, P_BL} phase_t;

    localparam logic [3:0] MIN_M1 = 4'(MIN_GREEN - 1);
    localparam logic [3:0] MAX_M1 = 4'(MAX_GREEN - 1);
    localparam logic [3:0] YEL_M1 = 4'(YELLOW - 1);

    state_t     state, state_n;
    phase_t     phase, phase_n;
    logic [3:0] cnt_n;
    logic       chg_n;
    logic [3:0] req, own_mask;
    logic       own, other;
    logic [1:0] idx;
    phase_t     succ;

    // Light code for a given state/phase: {La, Lb}.
    function automatic logic [3:0] lights(input state_t s, input phase_t p);
        logic [3:0] l;
        l = 4'b1111;
        case (s)
            S_GREEN: begin
                case (p)
                    P_A:     l = 4'b0011;
                    P_AL:    l = 4'b1011;
                    P_B:     l = 4'b1100;
                    default: l = 4'b1110;
                endcase
            end
            S_YELLOW: l = (p == P_A || p == P_AL) ? 4'b0111 : 4'b1101;
            default:  l = 4'b1111;
        endcase
        return l;
    endfunction

    always_comb begin
        req      = {Tbl, Tb, Tal, Ta};
        own_mask = 4'b0001 << phase;
        own      = |(req & own_mask);
        other    = |(req & ~own_mask);

        // Scan from farthest to nearest so the nearest asserted request after p wins;
        // offset 4 wraps to p itself, and with no request the successor is kept.
        succ = phase_t'(2'(phase) + 2'd1);
        idx  = 2'(phase);
        for (int k = 4; k >= 1; k--) begin
            idx = 2'(phase) + 2'(k);
            if (req[idx]) succ = phase_t'(idx);
        end

        state_n = state;
        phase_n = phase;
        cnt_n   = (cnt == 4'hF) ? cnt : cnt + 4'd1;
        chg_n   = 1'b0;

        if (emg) begin
            state_n = S_ALL_RED;
            if (state != S_ALL_RED) cnt_n = 4'd0;
        end else begin
            case (state)
                S_GREEN: begin
                    if (other && ((cnt >= MIN_M1 && !own) || cnt >= MAX_M1)) begin
                        state_n = S_YELLOW;
                        cnt_n   = 4'd0;
                    end
                end
                S_YELLOW: begin
                    if (cnt == YEL_M1) begin
                        state_n = S_GREEN;
                        phase_n = succ;
                        cnt_n   = 4'd0;
                        chg_n   = 1'b1;
                    end
                end
                S_ALL_RED: begin
                    state_n = S_GREEN;
                    phase_n = P_A;
                    cnt_n   = 4'd0;
                    chg_n   = 1'b1;
                end
                default: begin
                    state_n = S_GREEN;
                    phase_n = P_A;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_GREEN;
            phase <= P_A;
            cnt   <= 4'd0;
            chg   <= 1'b0;
            La    <= 2'b00;
            Lb    <= 2'b11;
            gnt   <= 4'b0001;
        end else begin
            state <= state_n;
            phase <= phase_n;
            cnt   <= cnt_n;
            chg   <= chg_n;
            {La, Lb} <= lights(state_n, phase_n);
            gnt   <= (state_n == S_GREEN) ? (4'b0001 << phase_n) : 4'b0000;
        end
    end

endmodule

// File: tb/tb_tl_phase_sched.sv
// Directed bench for tl_phase_sched: a monitor pops expected {cycle, La, Lb, gnt}
// on every chg pulse; the stimulus process pushes them and checks levels directly.
module tb_tl_phase_sched;

    logic       clk, reset;
    logic       Ta, Tal, Tb, Tbl, emg;
    logic [1:0] La, Lb;
    logic [3:0] gnt, cnt;
    logic       chg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [15:0] exp_q[$];

    tl_phase_sched #(.MIN_GREEN(4), .MAX_GREEN(8), .YELLOW(2)) dut (
        .clk(clk), .reset(reset),
        .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl), .emg(emg),
        .La(La), .Lb(Lb), .gnt(gnt), .chg(chg), .cnt(cnt)
    );

    // clock / reset / cycle count since reset release
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) if (!reset) cyc = cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] la, input logic [1:0] lb, input logic [3:0] g);
        exp_q.push_back({8'(c), la, lb, g});
    endtask

    task automatic set_req(input logic a, input logic al, input logic b, input logic bl);
        Ta = a; Tal = al; Tb = b; Tbl = bl;
    endtask

    task automatic apply_reset();
        #1;
        reset = 1'b1;
        cyc   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        check(name, 16'(exp_q.size()), 16'd0);
        exp_q.delete();
    endtask

    // monitor: every green start must match the next queued expectation
    always @(negedge clk) begin
        if (!reset && chg) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_chg: got La=%b Lb=%b gnt=%b at cycle %0d, required no chg", La, Lb, gnt, cyc);
            end else begin
                check("green_start", {8'(cyc), La, Lb, gnt}, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        emg   = 1'b0;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);

        // reset values, then PA<->PB alternation at a 10-cycle period
        apply_reset();
        check("rst_lights", 16'({La, Lb}), 16'b0011);
        check("rst_gnt", 16'(gnt), 16'b0001);
        check("rst_cnt_chg", 16'({cnt, chg}), 16'd0);
        push(10, 2'b11, 2'b00, 4'b0100);
        push(20, 2'b00, 2'b11, 4'b0001);
        push(30, 2'b11, 2'b00, 4'b0100);
        wait_cyc(1);
        check("first_edge_cnt", 16'(cnt), 16'd1);
        check("first_edge_gnt_chg", 16'({gnt, chg}), 16'b00010);
        wait_cyc(8);
        check("pa_yellow", 16'({La, Lb, gnt}), 16'b01110000);
        wait_cyc(32);
        drain("alt_drain");

        // PA yields at MIN_GREEN when its own request is low, then PAL
        set_req(1'b0, 1'b1, 1'b0, 1'b0);
        apply_reset();
        push(6, 2'b10, 2'b11, 4'b0010);
        wait_cyc(4);
        check("pal_y0", 16'(La), 16'b01);
        wait_cyc(5);
        check("pal_y1", 16'(La), 16'b01);
        wait_cyc(12);
        drain("pal_drain");

        // no requests: PA holds, cnt saturates
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        apply_reset();
        wait_cyc(50);
        check("idle_lights", 16'({La, Lb, gnt}), 16'b00110001);
        check("idle_cnt", 16'(cnt), 16'd15);
        drain("idle_drain");

        // Tb raised during PA yellow: PB beats PBL, PBL follows after PB
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        apply_reset();
        push(6, 2'b11, 2'b00, 4'b0100);
        push(16, 2'b11, 2'b10, 4'b1000);
        wait_cyc(4);
        check("rr_yellow", 16'({La, Lb}), 16'b0111);
        Tb = 1'b1;
        wait_cyc(20);
        drain("rr_drain");

        // emergency during PB green at cnt=2
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        apply_reset();
        push(6, 2'b11, 2'b00, 4'b0100);
        wait_cyc(8);
        check("pb_cnt2", 16'({gnt, cnt}), 16'b01000010);
        emg = 1'b1;
        for (int c = 9; c <= 11; c++) begin
            wait_cyc(c);
            check("all_red", 16'({La, Lb, gnt}), 16'b11110000);
        end
        emg = 1'b0;
        push(12, 2'b00, 2'b11, 4'b0001);
        wait_cyc(13);
        drain("emg_drain");

        // asynchronous reset in the middle of PB yellow
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        apply_reset();
        push(10, 2'b11, 2'b00, 4'b0100);
        wait_cyc(18);
        check("pb_yellow", 16'({La, Lb}), 16'b1101);
        #2 reset = 1'b1;
        #1;
        check("async_lights", 16'({La, Lb, gnt}), 16'b00110001);
        check("async_cnt_chg", 16'({cnt, chg}), 16'd0);
        drain("async_drain");
        apply_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
